// File: rtl/alu_ctrl_decode.sv
// RV32I decode stage: turns an instruction/PC pair into a registered ID/EX slot
// carrying the ALU control code, operand selects, immediate and pipeline controls.
module alu_ctrl_decode #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC_TAG = {XLEN{1'b0}}
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [4:0]      ALU_control,
   output logic [1:0]      a_sel,
   output logic            b_sel,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic            reg_write,
   output logic            mem_read,
   output logic            mem_write,
   output logic            branch,
   output logic            br_on_zero,
   output logic            jump,
   output logic            wb_invert,
   output logic            illegal,
   output logic [XLEN-1:0] ex_pc
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_REG    = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00010;
   localparam logic [4:0] ALU_SLL  = 5'b00100;
   localparam logic [4:0] ALU_SLT  = 5'b01000;
   localparam logic [4:0] ALU_SLTU = 5'b01100;
   localparam logic [4:0] ALU_XOR  = 5'b10000;
   localparam logic [4:0] ALU_SRL  = 5'b10100;
   localparam logic [4:0] ALU_SRA  = 5'b10110;
   localparam logic [4:0] ALU_OR   = 5'b11000;
   localparam logic [4:0] ALU_BGE  = 5'b11010;
   localparam logic [4:0] ALU_AND  = 5'b11100;
   localparam logic [4:0] ALU_BGEU = 5'b11110;
   localparam logic [4:0] ALU_PASS = 5'b11111;

   logic [6:0]      opcode_s;
   logic [2:0]      funct3_s;
   logic [6:0]      funct7_s;
   logic [31:0]     imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, shamt_s;
   logic [31:0]     imm32_s;
   logic [XLEN-1:0] imm_ext_s;
   logic [4:0]      alu_s;
   logic [1:0]      a_sel_s;
   logic            b_sel_s, reg_write_s, mem_read_s, mem_write_s;
   logic            branch_s, br_on_zero_s, jump_s, wb_invert_s, illegal_s;
   logic            load_s;

   assign opcode_s = in_instr[6:0];
   assign funct3_s = in_instr[14:12];
   assign funct7_s = in_instr[31:25];

   assign imm_i_s = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
   assign imm_u_s = {in_instr[31:12], 12'h000};
   assign imm_j_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
   assign shamt_s = {27'd0, in_instr[24:20]};

   assign imm_ext_s = XLEN'($signed(imm32_s));

   assign in_ready = !ex_valid || ex_ready;
   assign load_s   = in_valid && in_ready;

   // Instruction decode into slot controls
   always_comb begin
      alu_s        = ALU_ADD;
      a_sel_s      = 2'b00;
      b_sel_s      = 1'b0;
      imm32_s      = 32'h0000_0000;
      reg_write_s  = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      branch_s     = 1'b0;
      br_on_zero_s = 1'b0;
      jump_s       = 1'b0;
      wb_invert_s  = 1'b0;
      illegal_s    = 1'b0;
      case (opcode_s)
         OPC_LUI: begin
            alu_s = ALU_PASS; a_sel_s = 2'b10; b_sel_s = 1'b1;
            imm32_s = imm_u_s; reg_write_s = 1'b1;
         end
         OPC_AUIPC: begin
            alu_s = ALU_PASS; a_sel_s = 2'b01; b_sel_s = 1'b1;
            imm32_s = imm_u_s; reg_write_s = 1'b1;
         end
         OPC_JAL: begin
            a_sel_s = 2'b01; b_sel_s = 1'b1; imm32_s = imm_j_s;
            jump_s = 1'b1; reg_write_s = 1'b1;
         end
         OPC_JALR: begin
            b_sel_s = 1'b1; imm32_s = imm_i_s; jump_s = 1'b1; reg_write_s = 1'b1;
            illegal_s = (funct3_s != 3'b000);
         end
         OPC_LOAD: begin
            b_sel_s = 1'b1; imm32_s = imm_i_s; reg_write_s = 1'b1; mem_read_s = 1'b1;
         end
         OPC_STORE: begin
            b_sel_s = 1'b1; imm32_s = imm_s_s; mem_write_s = 1'b1;
         end
         OPC_BRANCH: begin
            branch_s = 1'b1; imm32_s = imm_b_s;
            // br_on_zero marks the compares whose taken condition is "ALU result zero"
            case (funct3_s)
               3'b000:  begin alu_s = ALU_SUB;  br_on_zero_s = 1'b1; end
               3'b001:  alu_s = ALU_SUB;
               3'b100:  alu_s = ALU_SLT;
               3'b101:  begin alu_s = ALU_BGE;  br_on_zero_s = 1'b1; end
               3'b110:  begin alu_s = ALU_SLTU; br_on_zero_s = 1'b1; end
               3'b111:  begin alu_s = ALU_BGEU; br_on_zero_s = 1'b1; end
               default: illegal_s = 1'b1;
            endcase
         end
         OPC_IMM: begin
            b_sel_s = 1'b1; reg_write_s = 1'b1; imm32_s = imm_i_s;
            case (funct3_s)
               3'b000:  alu_s = ALU_ADD;
               3'b010:  alu_s = ALU_SLT;
               3'b011:  begin alu_s = ALU_SLTU; wb_invert_s = 1'b1; end
               3'b100:  alu_s = ALU_XOR;
               3'b110:  alu_s = ALU_OR;
               3'b111:  alu_s = ALU_AND;
               3'b001: begin
                  alu_s = ALU_SLL; imm32_s = shamt_s;
                  illegal_s = (funct7_s != F7_BASE);
               end
               3'b101: begin
                  imm32_s = shamt_s;
                  alu_s = (funct7_s == F7_ALT) ? ALU_SRA : ALU_SRL;
                  illegal_s = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
               end
               default: illegal_s = 1'b1;
            endcase
         end
         OPC_REG: begin
            reg_write_s = 1'b1;
            case ({funct7_s, funct3_s})
               {F7_BASE, 3'b000}: alu_s = ALU_ADD;
               {F7_BASE, 3'b001}: alu_s = ALU_SLL;
               {F7_BASE, 3'b010}: alu_s = ALU_SLT;
               {F7_BASE, 3'b011}: begin alu_s = ALU_SLTU; wb_invert_s = 1'b1; end
               {F7_BASE, 3'b100}: alu_s = ALU_XOR;
               {F7_BASE, 3'b101}: alu_s = ALU_SRL;
               {F7_BASE, 3'b110}: alu_s = ALU_OR;
               {F7_BASE, 3'b111}: alu_s = ALU_AND;
               {F7_ALT,  3'b000}: alu_s = ALU_SUB;
               {F7_ALT,  3'b101}: alu_s = ALU_SRA;
               default:           illegal_s = 1'b1;
            endcase
         end
         default: illegal_s = 1'b1;
      endcase
   end

   // ID/EX slot: flush beats load, load beats drain, otherwise everything holds
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ex_valid    <= 1'b0;
         ALU_control <= ALU_ADD;
         a_sel       <= 2'b00;
         b_sel       <= 1'b0;
         imm         <= {XLEN{1'b0}};
         rs1         <= 5'd0;
         rs2         <= 5'd0;
         rd          <= 5'd0;
         reg_write   <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         branch      <= 1'b0;
         br_on_zero  <= 1'b0;
         jump        <= 1'b0;
         wb_invert   <= 1'b0;
         illegal     <= 1'b0;
         ex_pc       <= RESET_PC_TAG;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (load_s) begin
         ex_valid <= 1'b1;
         ex_pc    <= in_pc;
         rs1      <= in_instr[19:15];
         rs2      <= in_instr[24:20];
         rd       <= in_instr[11:7];
         // Unsupported encodings still occupy the slot so the trap logic sees them
         if (illegal_s) begin
            ALU_control <= ALU_ADD;
            a_sel       <= 2'b00;
            b_sel       <= 1'b0;
            imm         <= {XLEN{1'b0}};
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            branch      <= 1'b0;
            br_on_zero  <= 1'b0;
            jump        <= 1'b0;
            wb_invert   <= 1'b0;
            illegal     <= 1'b1;
         end else begin
            ALU_control <= alu_s;
            a_sel       <= a_sel_s;
            b_sel       <= b_sel_s;
            imm         <= imm_ext_s;
            reg_write   <= reg_write_s;
            mem_read    <= mem_read_s;
            mem_write   <= mem_write_s;
            branch      <= branch_s;
            br_on_zero  <= br_on_zero_s;
            jump        <= jump_s;
            wb_invert   <= wb_invert_s;
            illegal     <= 1'b0;
         end
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end else begin
         ex_valid <= ex_valid;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Bench for alu_ctrl_decode: directed cases plus random traffic, all compared
// against a mnemonic-level decode model and a simple slot occupancy model.
`timescale 1ns/1ps
module tb_alu_ctrl_decode;

   localparam logic [31:0] PC_TAG = 32'h0000_0100;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        in_valid, in_ready, flush, ex_valid, ex_ready;
   logic [31:0] in_instr, in_pc, imm, ex_pc;
   logic [4:0]  ALU_control, rs1, rs2, rd;
   logic [1:0]  a_sel;
   logic        b_sel, reg_write, mem_read, mem_write, branch, br_on_zero;
   logic        jump, wb_invert, illegal;

   always #5 CLK = ~CLK;

   alu_ctrl_decode #(.XLEN(32), .RESET_PC_TAG(PC_TAG)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_valid(ex_valid),
      .ex_ready(ex_ready), .ALU_control(ALU_control), .a_sel(a_sel), .b_sel(b_sel),
      .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
      .br_on_zero(br_on_zero), .jump(jump), .wb_invert(wb_invert),
      .illegal(illegal), .ex_pc(ex_pc)
   );

   typedef enum {
      M_ILL, M_LUI, M_AUIPC, M_JAL, M_JALR, M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU,
      M_LOAD, M_STORE, M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI,
      M_SRAI, M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND
   } mn_t;

   typedef struct {
      logic        valid;
      logic [4:0]  alu;
      logic [1:0]  a_sel;
      logic        b_sel;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic        rw, mr, mw, br, boz, jmp, inv, ill;
      logic [31:0] pc;
   } slot_t;

   slot_t exp_s;
   int    n_checks = 0;
   int    n_bad    = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
      end
   endtask

   // Sign-extend the low 'bits' bits of v
   function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
      logic [31:0] sign;
      sign = 32'h1 << (bits - 1);
      return (v ^ sign) - sign;
   endfunction

   function automatic slot_t ref_decode(input logic [31:0] w);
      slot_t s;
      mn_t   m;
      mn_t   bn[8];
      mn_t   in[8];
      mn_t   rn[8];
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = w[14:12];
      f7 = w[31:25];
      bn = '{M_BEQ, M_BNE, M_ILL, M_ILL, M_BLT, M_BGE, M_BLTU, M_BGEU};
      in = '{M_ADDI, M_SLLI, M_SLTI, M_SLTIU, M_XORI, M_SRLI, M_ORI, M_ANDI};
      rn = '{M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND};
      case (w[6:0])
         7'h37: m = M_LUI;
         7'h17: m = M_AUIPC;
         7'h6F: m = M_JAL;
         7'h67: if (f3 == 3'd0) m = M_JALR; else m = M_ILL;
         7'h63: m = bn[f3];
         7'h03: m = M_LOAD;
         7'h23: m = M_STORE;
         7'h13: begin
            m = in[f3];
            if (f3 == 3'd5 && f7 == 7'h20) m = M_SRAI;
            else if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) m = M_ILL;
         end
         7'h33: begin
            if (f7 == 7'h00) m = rn[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) m = M_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) m = M_SRA;
            else m = M_ILL;
         end
         default: m = M_ILL;
      endcase

      s.valid = 1'b1; s.pc = 32'h0;
      s.rs1 = w[19:15]; s.rs2 = w[24:20]; s.rd = w[11:7];
      s.alu = 5'b00000; s.a_sel = 2'b00; s.b_sel = 1'b0; s.imm = 32'h0;
      s.rw = 1'b0; s.mr = 1'b0; s.mw = 1'b0; s.br = 1'b0; s.boz = 1'b0;
      s.jmp = 1'b0; s.inv = 1'b0; s.ill = 1'b0;

      case (m)
         M_ADD, M_ADDI, M_LOAD, M_STORE, M_JAL, M_JALR: s.alu = 5'b00000;
         M_SUB, M_BEQ, M_BNE:    s.alu = 5'b00010;
         M_SLL, M_SLLI:          s.alu = 5'b00100;
         M_SLT, M_SLTI, M_BLT:   s.alu = 5'b01000;
         M_SLTU, M_SLTIU, M_BLTU: s.alu = 5'b01100;
         M_XOR, M_XORI:          s.alu = 5'b10000;
         M_SRL, M_SRLI:          s.alu = 5'b10100;
         M_SRA, M_SRAI:          s.alu = 5'b10110;
         M_OR, M_ORI:            s.alu = 5'b11000;
         M_BGE:                  s.alu = 5'b11010;
         M_AND, M_ANDI:          s.alu = 5'b11100;
         M_BGEU:                 s.alu = 5'b11110;
         M_LUI, M_AUIPC:         s.alu = 5'b11111;
         default:                s.ill = 1'b1;
      endcase

      if (!s.ill) begin
         s.inv = (m == M_SLTU) || (m == M_SLTIU);
         case (m)
            M_LUI:   begin s.a_sel = 2'b10; s.b_sel = 1'b1; s.imm = w & 32'hFFFF_F000; s.rw = 1'b1; end
            M_AUIPC: begin s.a_sel = 2'b01; s.b_sel = 1'b1; s.imm = w & 32'hFFFF_F000; s.rw = 1'b1; end
            M_JAL: begin
               s.a_sel = 2'b01; s.b_sel = 1'b1; s.jmp = 1'b1; s.rw = 1'b1;
               s.imm = sext({w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
            end
            M_JALR:  begin s.b_sel = 1'b1; s.jmp = 1'b1; s.rw = 1'b1; s.imm = sext(w >> 20, 12); end
            M_LOAD:  begin s.b_sel = 1'b1; s.rw = 1'b1; s.mr = 1'b1; s.imm = sext(w >> 20, 12); end
            M_STORE: begin s.b_sel = 1'b1; s.mw = 1'b1; s.imm = sext({w[31:25], w[11:7]}, 12); end
            M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU: begin
               s.br  = 1'b1;
               s.imm = sext({w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
               s.boz = (m == M_BEQ) || (m == M_BGE) || (m == M_BLTU) || (m == M_BGEU);
            end
            M_SLLI, M_SRLI, M_SRAI: begin s.b_sel = 1'b1; s.rw = 1'b1; s.imm = {27'd0, w[24:20]}; end
            M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI: begin
               s.b_sel = 1'b1; s.rw = 1'b1; s.imm = sext(w >> 20, 12);
            end
            default: s.rw = 1'b1;
         endcase
      end
      return s;
   endfunction

   task automatic reset_model();
      exp_s = ref_decode(32'h0000_0013);
      exp_s.valid = 1'b0; exp_s.alu = 5'd0; exp_s.a_sel = 2'd0; exp_s.b_sel = 1'b0;
      exp_s.imm = 32'h0; exp_s.rs1 = 5'd0; exp_s.rs2 = 5'd0; exp_s.rd = 5'd0;
      exp_s.rw = 1'b0; exp_s.mr = 1'b0; exp_s.mw = 1'b0; exp_s.br = 1'b0;
      exp_s.boz = 1'b0; exp_s.jmp = 1'b0; exp_s.inv = 1'b0; exp_s.ill = 1'b0;
      exp_s.pc = PC_TAG;
   endtask

   task automatic compare_all(input string ph);
      check_eq({ph, ".ex_valid"},    ex_valid,    exp_s.valid);
      check_eq({ph, ".ALU_control"}, ALU_control, exp_s.alu);
      check_eq({ph, ".a_sel"},       a_sel,       exp_s.a_sel);
      check_eq({ph, ".b_sel"},       b_sel,       exp_s.b_sel);
      check_eq({ph, ".imm"},         imm,         exp_s.imm);
      check_eq({ph, ".rs1"},         rs1,         exp_s.rs1);
      check_eq({ph, ".rs2"},         rs2,         exp_s.rs2);
      check_eq({ph, ".rd"},          rd,          exp_s.rd);
      check_eq({ph, ".reg_write"},   reg_write,   exp_s.rw);
      check_eq({ph, ".mem_read"},    mem_read,    exp_s.mr);
      check_eq({ph, ".mem_write"},   mem_write,   exp_s.mw);
      check_eq({ph, ".branch"},      branch,      exp_s.br);
      check_eq({ph, ".br_on_zero"},  br_on_zero,  exp_s.boz);
      check_eq({ph, ".jump"},        jump,        exp_s.jmp);
      check_eq({ph, ".wb_invert"},   wb_invert,   exp_s.inv);
      check_eq({ph, ".illegal"},     illegal,     exp_s.ill);
      check_eq({ph, ".ex_pc"},       ex_pc,       exp_s.pc);
   endtask

   // One clock: drive at the falling edge, update the model, check at the next falling edge
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
      logic rdy_exp;
      in_valid = v; in_instr = ins; in_pc = pc; ex_ready = rdy; flush = fl;
      #1;
      rdy_exp = !exp_s.valid || rdy;
      check_eq("in_ready", in_ready, rdy_exp);
      if (fl) begin
         exp_s.valid = 1'b0;
      end else if (v && rdy_exp) begin
         exp_s    = ref_decode(ins);
         exp_s.pc = pc;
      end else if (rdy) begin
         exp_s.valid = 1'b0;
      end
      @(posedge CLK);
      @(negedge CLK);
      compare_all("slot");
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops[10];
      logic [31:0] w;
      logic [6:0]  op;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h00};
      w  = $urandom;
      op = ops[$urandom_range(0, 9)];
      if (op == 7'h00) op = 7'($urandom);
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (op == 7'h67 && $urandom_range(0, 1) == 1) w[14:12] = 3'b000;
      w[6:0] = op;
      return w;
   endfunction

   initial begin
      RESET_N = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
      ex_ready = 1'b0; flush = 1'b0;
      reset_model();
      #3 RESET_N = 1'b0;
      @(negedge CLK);
      compare_all("reset");
      RESET_N = 1'b1;

      // sub a0,a0,a1
      cycle(1'b1, 32'h40B5_0533, 32'h0000_1000, 1'b1, 1'b0);
      check_eq("sub.alu", ALU_control, 32'h02);
      check_eq("sub.rd", rd, 32'd10);
      check_eq("sub.rs1", rs1, 32'd10);
      check_eq("sub.rs2", rs2, 32'd11);
      check_eq("sub.rw", reg_write, 32'd1);
      check_eq("sub.b_sel", b_sel, 32'd0);

      // blt a0,x0,-16 then bgeu a0,a1,+8
      cycle(1'b1, 32'hFE05_48E3, 32'h0000_1004, 1'b1, 1'b0);
      check_eq("blt.alu", ALU_control, 32'h08);
      check_eq("blt.branch", branch, 32'd1);
      check_eq("blt.boz", br_on_zero, 32'd0);
      check_eq("blt.imm", imm, 32'hFFFF_FFF0);
      cycle(1'b1, 32'h00B5_7463, 32'h0000_1008, 1'b1, 1'b0);
      check_eq("bgeu.alu", ALU_control, 32'h1E);
      check_eq("bgeu.boz", br_on_zero, 32'd1);
      check_eq("bgeu.imm", imm, 32'd8);

      // sltiu a0,a1,5 and lui a0,0x12345
      cycle(1'b1, 32'h0055_B513, 32'h0000_100C, 1'b1, 1'b0);
      check_eq("sltiu.alu", ALU_control, 32'h0C);
      check_eq("sltiu.inv", wb_invert, 32'd1);
      check_eq("sltiu.b_sel", b_sel, 32'd1);
      check_eq("sltiu.imm", imm, 32'd5);
      cycle(1'b1, 32'h1234_5537, 32'h0000_1010, 1'b1, 1'b0);
      check_eq("lui.alu", ALU_control, 32'h1F);
      check_eq("lui.a_sel", a_sel, 32'd2);
      check_eq("lui.imm", imm, 32'h1234_5000);

      // Back-pressure: slot holds for three cycles, then loads with no bubble
      cycle(1'b1, 32'h00B5_0533, 32'h0000_2000, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'h0015_0513, 32'h0000_2004, 1'b0, 1'b0);
         check_eq("bp.in_ready", in_ready, 32'd0);
         check_eq("bp.hold_pc", ex_pc, 32'h0000_2000);
      end
      cycle(1'b1, 32'h0015_0513, 32'h0000_2004, 1'b1, 1'b0);
      check_eq("bp.load_pc", ex_pc, 32'h0000_2004);
      cycle(1'b1, 32'h0025_0513, 32'h0000_2008, 1'b1, 1'b0);
      check_eq("bp.next_valid", ex_valid, 32'd1);
      check_eq("bp.next_pc", ex_pc, 32'h0000_2008);
      cycle(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
      check_eq("drain.valid", ex_valid, 32'd0);

      // Flush on an accepted instruction, then an illegal opcode
      cycle(1'b1, 32'h0035_0513, 32'h0000_3000, 1'b1, 1'b1);
      check_eq("flush.valid", ex_valid, 32'd0);
      cycle(1'b1, 32'h0000_007F, 32'h0000_3004, 1'b1, 1'b0);
      check_eq("ill.valid", ex_valid, 32'd1);
      check_eq("ill.illegal", illegal, 32'd1);
      check_eq("ill.rw", reg_write, 32'd0);
      check_eq("ill.mw", mem_write, 32'd0);

      // Asynchronous reset while the slot is held
      cycle(1'b1, 32'h40B5_0533, 32'h0000_4000, 1'b1, 1'b0);
      cycle(1'b1, 32'h0015_0513, 32'h0000_4004, 1'b0, 1'b0);
      #2 RESET_N = 1'b0;
      #1;
      check_eq("areset.valid", ex_valid, 32'd0);
      check_eq("areset.alu", ALU_control, 32'd0);
      reset_model();
      @(negedge CLK);
      RESET_N = 1'b1;
      compare_all("post_reset");

      for (int i = 0; i < 2000; i++) begin
         cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
